// File: rtl/led7_scan_decoder_pkg.sv
// rtl/led7_scan_decoder_pkg.sv - segment pattern constants and FSM states for the seven-segment scan decoder
package led7_scan_decoder_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PUBLISH = 2'd2
    } state_t;

endpackage

// File: rtl/led7_scan_decoder_if.sv
// rtl/led7_scan_decoder_if.sv - segment/anode inputs and published-word outputs of the scan decoder
interface led7_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   an_in;
    logic [4*NUM_DIGITS-1:0] data_out;
    logic [NUM_DIGITS-1:0]   blank_out;
    logic                    valid_out;
    logic                    err_out;

    modport master (
        output seg_in, an_in,
        input  data_out, blank_out, valid_out, err_out
    );

    modport slave (
        input  seg_in, an_in,
        output data_out, blank_out, valid_out, err_out
    );
endinterface

// File: rtl/led7_scan_decoder_to_bin.sv
// rtl/led7_scan_decoder_to_bin.sv - combinational seven-segment pattern to nibble decoder
module led7_to_bin
    import led7_scan_decoder_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_value,
    output logic       o_blank,
    output logic       o_invalid
);
    always_comb begin
        o_value   = 4'h0;
        o_blank   = 1'b0;
        o_invalid = 1'b0;
        case (i_seg)
            SEG_0:     o_value = 4'h0;
            SEG_1:     o_value = 4'h1;
            SEG_2:     o_value = 4'h2;
            SEG_3:     o_value = 4'h3;
            SEG_4:     o_value = 4'h4;
            SEG_5:     o_value = 4'h5;
            SEG_6:     o_value = 4'h6;
            SEG_7:     o_value = 4'h7;
            SEG_8:     o_value = 4'h8;
            SEG_9:     o_value = 4'h9;
            SEG_A:     o_value = 4'hA;
            SEG_B:     o_value = 4'hB;
            SEG_C:     o_value = 4'hC;
            SEG_D:     o_value = 4'hD;
            SEG_E:     o_value = 4'hE;
            SEG_F:     o_value = 4'hF;
            SEG_BLANK: o_blank = 1'b1;
            default:   o_invalid = 1'b1;
        endcase
    end
endmodule

// File: rtl/led7_scan_decoder.sv
// rtl/led7_scan_decoder.sv - captures stable multiplexed digits and publishes each completed scan frame
module led7_scan_decoder
    import led7_scan_decoder_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    led7_scan_decoder_if.slave bus
);
    localparam int         IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int         SW      = NUM_DIGITS + 7;
    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);
    localparam logic [3:0] CNT_CAP = 4'(STABLE_CYCLES - 2);

    state_t                  r_state, w_state_nxt;
    logic [SW-1:0]           r_prev;
    logic [3:0]              r_cnt;
    logic [NUM_DIGITS-1:0]   r_mask, w_mask_nxt;
    logic [4*NUM_DIGITS-1:0] r_frame_val, r_data;
    logic [NUM_DIGITS-1:0]   r_frame_blank, r_blank;
    logic                    r_valid, r_err;
    logic                    w_publish, w_err_nxt;
    logic [SW-1:0]           w_sample;
    logic                    w_same, w_capture;
    logic [IW-1:0]           w_idx;
    logic [3:0]              w_value;
    logic                    w_blank, w_invalid;

    assign w_sample  = {bus.an_in, bus.seg_in};
    assign w_same    = $onehot(bus.an_in) && (w_sample == r_prev);
    // Counter value CNT_CAP is passed exactly once per dwell, so each dwell captures once.
    assign w_capture = w_same && (r_cnt == CNT_CAP);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.an_in[i]) w_idx = IW'(i);
        end
    end

    led7_to_bin u_to_bin (
        .i_seg    (bus.seg_in),
        .o_value  (w_value),
        .o_blank  (w_blank),
        .o_invalid(w_invalid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_cnt  <= '0;
        end else begin
            r_prev <= w_sample;
            if (!w_same)              r_cnt <= '0;
            else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 4'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_publish   = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE, COLLECT: ;
            PUBLISH: begin
                w_publish   = 1'b1;
                w_mask_nxt  = '0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        // A capture in the PUBLISH cycle lands in the freshly cleared mask.
        if (w_capture) begin
            if (w_invalid) begin
                w_err_nxt   = 1'b1;
                w_mask_nxt  = '0;
                w_state_nxt = IDLE;
            end else begin
                w_mask_nxt[w_idx] = 1'b1;
                w_state_nxt       = (&w_mask_nxt) ? PUBLISH : COLLECT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_val   <= '0;
            r_frame_blank <= '0;
        end else if (w_capture && !w_invalid) begin
            r_frame_val[{w_idx, 2'b00} +: 4] <= w_value;
            r_frame_blank[w_idx]             <= w_blank;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_blank <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_publish;
            r_err   <= w_err_nxt;
            if (w_publish) begin
                r_data  <= r_frame_val;
                r_blank <= r_frame_blank;
            end
        end
    end

    assign bus.data_out  = r_data;
    assign bus.blank_out = r_blank;
    assign bus.valid_out = r_valid;
    assign bus.err_out   = r_err;
endmodule

// File: doc/led7_scan_decoder.md
# led7_scan_decoder

Receiving end of a multiplexed seven-segment display link. It watches the segment bus and the digit-select lines driven by a hex display encoder/scanner. It waits for each digit's pattern to be stable, then decodes it back to a 4-bit value. Once every digit of a scan frame has been captured, it publishes the assembled word. It sits on the loopback/self-check path beside the display driver and feeds a status register with the displayed value.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits; one anode line per digit
- STABLE_CYCLES, 3, consecutive identical samples required before a digit is captured; legal range 2..15
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- seg_in  input  7  segment bus {g,f,e,d,c,b,a}, active-high
- an_in  input  NUM_DIGITS  digit select, one-hot active-high; bit i selects digit i (nibble i of data_out)
- data_out  output  4*NUM_DIGITS  last published word; digit i in bits [4i+3:4i]
- blank_out  output  NUM_DIGITS  bit i set if digit i was blank in the published frame
- valid_out  output  1  one-cycle pulse when data_out/blank_out update
- err_out  output  1  one-cycle pulse on an undecodable pattern

## Operation
- Pattern map: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71 (hex, seg_in).
- Blank: 00 decodes to nibble 0 with the blank flag set (the encoder's disabled output).
- Any other pattern is invalid.
- Stability counter:
  - Increments, saturating at STABLE_CYCLES, while an_in is one-hot and {an_in, seg_in} equals the previous cycle's sample.
  - Any change, or an an_in value that is zero or multi-hot, clears it to 0 and re-arms capture.
- Capture: exactly once per dwell, on the cycle the counter reaches STABLE_CYCLES-1, i.e. the STABLE_CYCLES-th identical sample.
  - Valid or blank: write the nibble and blank bit into the frame buffer slot for the selected digit, and set that digit's seen-mask bit. A re-capture of a digit within a frame overwrites its slot.
  - Invalid: pulse err_out, clear the seen mask and return to IDLE. data_out and blank_out are untouched.
- FSM:
  - IDLE: seen mask empty. Goes to COLLECT on a valid capture.
  - COLLECT: accumulates captures. Goes to PUBLISH when the mask becomes all ones. Goes to IDLE on an invalid capture.
  - PUBLISH: one cycle. Copies the frame buffer to data_out/blank_out, asserts valid_out, clears the mask, goes to IDLE.
- A capture arriving in the PUBLISH cycle is taken into the new (cleared) frame and moves the FSM to COLLECT.
- Digit order within a frame is free; frames are not required to start at digit 0.

## Timing
- Reset (async assert, sync release):
  - data_out=0, blank_out=0, valid_out=0, err_out=0.
  - Counter and mask cleared, FSM IDLE.
  - Reset mid-frame discards all partial captures.
- Input sampled on edge k, held constant: capture at edge k+STABLE_CYCLES-1.
- If that capture completes the frame:
  - PUBLISH in the following cycle.
  - valid_out high for the one cycle after edge k+STABLE_CYCLES.
  - data_out valid from that same edge and held until the next publish.
- err_out is high for the one cycle after the capture edge of the invalid pattern.
- A dwell shorter than STABLE_CYCLES samples is ignored silently.

## Structure
- Shared include/package: the 16 segment pattern constants, the BLANK constant, and the FSM state encodings (IDLE, COLLECT, PUBLISH).
- One combinational sub-module, led7_to_bin: 7-bit pattern in → 4-bit value, blank, invalid.
- Stability counter, frame buffer and FSM live in the top module.

## Test plan
- Frame 1,2,3,4: drive an_in=0001..1000 with 06,5B,4F,66, 5 cycles each. Expect one valid_out with data_out=16'h4321, blank_out=0.
- Glitch rejection: digit 0 shows 7F for only 2 cycles, then 3F for 5 cycles; digits 1..3 show 06. Expect data_out=16'h1110; no capture of 8.
- Blank digit: digit 3 shows 00, others show 71. Expect data_out=16'h0FFF, blank_out=4'b1000.
- Invalid pattern: digit 2 shows 7E mid-frame. Expect err_out pulse, no valid_out for that frame. The next clean frame of 5,5,5,5 publishes 16'h5555.
- Multi-hot/zero an_in: an_in=0011 or 0000 for 10 cycles. Expect no capture, no err_out, no valid_out.
- Async reset: assert rst_n=0 after 3 of 4 digits are captured. Expect outputs 0 immediately. After release, one more digit produces no valid_out; only a full new frame publishes.
